regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters: the ALU/execute path (requester 0) and the load/memory path (requester 1). Also keeps a per-register busy scoreboard so decode can stall on operands with outstanding writes. Sits between the execute/memory stages and the register file's write port. Registers the granted write one cycle before it reaches the register file.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register-file write port between the ALU writeback path
//   (requester 0) and the load path (requester 1). The granted write is
//   registered once before it reaches the register file. A per-register busy
//   scoreboard lets decode stall on operands that still have outstanding
//   writes.
//
//   Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration.
//   Without it, requester 1 (load) always wins a conflict.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_reqN_valid/addr/data     writeback request from requester N (0 = ALU, 1 = load)
//   o_reqN_ready               request accepted this cycle (combinational)
//   o_wr_en/addr/data          registered write to the register file
//   i_issue_valid, i_issue_rd  decode issues an instruction writing rd
//   o_issue_stall              issue blocked: rd already has an outstanding write
//   i_rs1_addr, i_rs2_addr     decode operand query addresses
//   o_rs1_busy, o_rs2_busy     operand has an outstanding write
module regfile_wb_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [4:0]       i_req0_addr,
  input  logic [WIDTH-1:0] i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [4:0]       i_req1_addr,
  input  logic [WIDTH-1:0] i_req1_data,
  output logic             o_req1_ready,
  output logic             o_wr_en,
  output logic [4:0]       o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  input  logic             i_issue_valid,
  input  logic [4:0]       i_issue_rd,
  output logic             o_issue_stall,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  logic             w_pick1;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_any_grant;
  logic [4:0]       w_win_addr;
  logic [WIDTH-1:0] w_win_data;

  logic             r_wr_en;
  logic [4:0]       r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;

  logic [31:1]      r_busy;
  logic [31:1]      w_busy_nxt;
  logic [31:0]      w_busy_vec;
  logic             w_issue_set;

  // w_pick1 decides only a conflict; a lone requester is always granted.
`ifdef WB_ARB_ROUND_ROBIN_EN
  // Last-grant pointer; resets to 1 so requester 0 wins the first conflict.
  logic r_last;

  assign w_pick1 = ~r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (w_any_grant) begin
      r_last <= w_grant1;
    end
  end
`else
  assign w_pick1 = 1'b1;
`endif

  assign w_grant1    = i_req1_valid & (~i_req0_valid | w_pick1);
  assign w_grant0    = i_req0_valid & (~i_req1_valid | ~w_pick1);
  assign w_any_grant = w_grant0 | w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  assign w_win_addr = w_grant1 ? i_req1_addr : i_req0_addr;
  assign w_win_data = w_grant1 ? i_req1_data : i_req0_data;

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= '0;
    end else if (w_any_grant) begin
      r_wr_en   <= (w_win_addr != 5'd0);
      r_wr_addr <= w_win_addr;
      r_wr_data <= w_win_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

  // x0 is hard-wired not busy.
  assign w_busy_vec    = {r_busy, 1'b0};
  assign o_issue_stall = i_issue_valid && (i_issue_rd != 5'd0) && w_busy_vec[i_issue_rd];
  assign w_issue_set   = i_issue_valid && !o_issue_stall && (i_issue_rd != 5'd0);

  // Clear from the commit is applied first so a same-edge issue set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < 32; i++) begin
      if (r_wr_en && (r_wr_addr == 5'(i))) w_busy_nxt[i] = 1'b0;
      if (w_issue_set && (i_issue_rd == 5'(i))) w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_rs1_busy = w_busy_vec[i_rs1_addr];
  assign o_rs2_busy = w_busy_vec[i_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0v, r1v, iss_v;
  logic [4:0]  r0a, r1a, iss_rd, rs1, rs2;
  logic [31:0] r0d, r1d;
  logic        rdy0, rdy1, wr_en, stall, b1, b2;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state
  bit [31:0] m_busy;
  bit        m_wr_en;
  bit [4:0]  m_wr_addr;
  bit [31:0] m_wr_data;
  bit        m_last;
  bit        g0, g1;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(r0v), .i_req0_addr(r0a), .i_req0_data(r0d), .o_req0_ready(rdy0),
    .i_req1_valid(r1v), .i_req1_addr(r1a), .i_req1_data(r1d), .o_req1_ready(rdy1),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_issue_valid(iss_v), .i_issue_rd(iss_rd), .o_issue_stall(stall),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .o_rs1_busy(b1), .o_rs2_busy(b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    r0v = 0; r0a = 0; r0d = 0;
    r1v = 0; r1a = 0; r1d = 0;
    iss_v = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; m_last = 1;
  endtask

  // Holds reset low for two edges, checks reset values, releases at edge+1.
  task automatic do_reset();
    rst_n = 0;
    idle();
    model_reset();
    rs1 = 5'd3; rs2 = 5'd7;
    @(posedge clk); #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    @(posedge clk); #1;
    chk("rst_busy1", 32'(b1), 0);
    chk("rst_busy2", 32'(b2), 0);
    rs1 = 0; rs2 = 0;
    rst_n = 1;
  endtask

  // One clock cycle: check everything against the model, then advance it.
  task automatic cyc();
    bit e0, e1, st;
    #1;
    e0 = 0; e1 = 0;
    if (r0v && r1v) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (m_last) e0 = 1; else e1 = 1;
`else
      e1 = 1;
`endif
    end else begin
      e0 = r0v; e1 = r1v;
    end
    st = iss_v && (iss_rd != 0) && m_busy[iss_rd];
    chk("ready0", 32'(rdy0), 32'(e0));
    chk("ready1", 32'(rdy1), 32'(e1));
    chk("issue_stall", 32'(stall), 32'(st));
    chk("rs1_busy", 32'(b1), 32'(m_busy[rs1]));
    chk("rs2_busy", 32'(b2), 32'(m_busy[rs2]));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      chk("wr_data", wr_data, m_wr_data);
    end
    g0 = e0; g1 = e1;
    @(posedge clk);
    if (m_wr_en) m_busy[m_wr_addr] = 0;
    if (iss_v && iss_rd != 0 && !st) m_busy[iss_rd] = 1;
    if (e0 || e1) begin
      m_wr_addr = e1 ? r1a : r0a;
      m_wr_data = e1 ? r1d : r0d;
      m_wr_en   = (m_wr_addr != 0);
      m_last    = e1;
    end else begin
      m_wr_en = 0;
    end
    #1;
  endtask

  initial begin
    bit exp0 [3];
    bit exp1 [3];
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp0 = '{1, 0, 1}; exp1 = '{0, 1, 0};
`else
    exp0 = '{0, 0, 0}; exp1 = '{1, 1, 1};
`endif
    idle();
    do_reset();

    // Single write
    r0v = 1; r0a = 5'd5; r0d = 32'hDEADBEEF;
    #1 chk("sw_ready0", 32'(rdy0), 1);
    cyc();
    idle();
    #1;
    chk("sw_wr_en", 32'(wr_en), 1);
    chk("sw_wr_addr", 32'(wr_addr), 5);
    chk("sw_wr_data", wr_data, 32'hDEADBEEF);
    cyc();
    chk("sw_wr_en_off", 32'(wr_en), 0);

    // Conflict, starting from the reset pointer
    do_reset();
    r0v = 1; r0a = 5'd1; r0d = 32'h11;
    r1v = 1; r1a = 5'd2; r1d = 32'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("conf_rdy0_%0d", k), 32'(rdy0), 32'(exp0[k]));
      chk($sformatf("conf_rdy1_%0d", k), 32'(rdy1), 32'(exp1[k]));
      cyc();
    end
    idle();
    cyc();

    // x0 write is accepted but does not write
    r1v = 1; r1a = 5'd0; r1d = 32'hFFFF;
    #1 chk("x0_ready1", 32'(rdy1), 1);
    cyc();
    idle();
    #1 chk("x0_wr_en", 32'(wr_en), 0);
    cyc();

    // Scoreboard set, WAW stall, commit clear
    iss_v = 1; iss_rd = 5'd7;
    cyc();
    rs1 = 5'd7;
    #1;
    chk("sb_busy7", 32'(b1), 1);
    chk("sb_stall7", 32'(stall), 1);
    cyc();
    iss_v = 0;
    r0v = 1; r0a = 5'd7; r0d = 32'h77;
    cyc();
    r0v = 0;
    #1;
    chk("sb_commit_en", 32'(wr_en), 1);
    chk("sb_busy_in_commit", 32'(b1), 1);
    cyc();
    #1 chk("sb_busy_after", 32'(b1), 0);
    cyc();

    // Same-edge set and clear on x9
    idle();
    r0v = 1; r0a = 5'd9; r0d = 32'h99;
    cyc();
    idle();
    iss_v = 1; iss_rd = 5'd9;
    #1;
    chk("se_wr_addr", 32'(wr_addr), 9);
    chk("se_stall", 32'(stall), 0);
    cyc();
    idle();
    rs1 = 5'd9;
    #1 chk("se_busy9", 32'(b1), 1);
    cyc();

    // Asynchronous reset while a write is pending and x3 is busy
    idle();
    iss_v = 1; iss_rd = 5'd3;
    r0v = 1; r0a = 5'd4; r0d = 32'h44;
    cyc();
    idle();
    rs1 = 5'd3;
    #1;
    chk("ar_wr_en_pre", 32'(wr_en), 1);
    chk("ar_busy3_pre", 32'(b1), 1);
    #2 rst_n = 0;
    #1;
    chk("ar_wr_en", 32'(wr_en), 0);
    chk("ar_busy3", 32'(b1), 0);
    do_reset();

    // Randomized traffic with requesters holding until accepted
    idle();
    for (int n = 0; n < 400; n++) begin
      if (!r0v && $urandom_range(0, 99) < 60) begin
        r0v = 1; r0a = 5'($urandom_range(0, 7)); r0d = $urandom;
      end
      if (!r1v && $urandom_range(0, 99) < 50) begin
        r1v = 1; r1a = 5'($urandom_range(0, 7)); r1d = $urandom;
      end
      iss_v  = ($urandom_range(0, 2) == 0);
      iss_rd = 5'($urandom_range(0, 7));
      rs1    = 5'($urandom_range(0, 7));
      rs2    = 5'($urandom_range(0, 7));
      cyc();
      if (r0v && g0) r0v = 0;
      if (r1v && g1) r1v = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
